rv32i_control_unit: RTL and testbench
=====================================

Name: rv32i_control_unit

Overview:
- Main decoder for the RV32I core: turns opcode, funct3 and funct7[5] of the current instruction into datapath control signals.
- Sits between instruction fetch/decode and execute. Outputs are registered, acting as the control half of the decode/execute pipeline register.
- Unknown opcodes decode to a NOP (all controls 0).

Parameters:
- none (RV32I base encodings fixed)

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  reset, asynchronous, active-low
- opcode  input  7  instruction[6:0]
- func_7_bit_6  input  1  instruction[30] (funct7 bit 5, selects SUB/SRA)
- func_3  input  3  instruction[14:12]
- write  output  1  register-file write enable
- store  output  1  data-memory write enable
- load  output  1  data-memory read / writeback-from-memory select
- branch  output  1  conditional-branch instruction flag (branch unit evaluates func_3)
- alu_operand_a_selector  output  2  ALU A: 00 rs1, 01 PC, 10 zero, 11 reserved (=zero)
- alu_operand_b_selector  output  1  ALU B: 0 rs2, 1 immediate
- immediate_selector  output  2  00 I-type, 01 S/B-type (immediate generator picks B when opcode[6]=1), 10 U-type, 11 J-type
- next_pc_selector  output  2  00 PC+4, 01 branch (PC+imm if taken else PC+4), 10 JAL target (ALU result), 11 JALR target (ALU result with bit0 cleared)
- alu_operations_selector  output  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; 10-15 unused

Behaviour:
- Reset: while rst_n=0 every output is 0 (write/store/load/branch=0, all selectors 00/0, ALU op ADD). Reset takes effect immediately, without waiting for a clock edge.
- Latency: combinational decode of the inputs is captured on each rising clk edge. Outputs change only at clock edges, exactly 1 cycle after the inputs are applied.
- Decode table (write, store, load, branch, A, B, imm, nextpc):
  - 0x33 R-type: 1,0,0,0, rs1, rs2, 00 (don't care, drive 00), 00
  - 0x13 I-ALU: 1,0,0,0, rs1, imm, I, 00
  - 0x03 load: 1,0,1,0, rs1, imm, I, 00; ALU ADD
  - 0x23 store: 0,1,0,0, rs1, imm, S/B, 00; ALU ADD
  - 0x63 branch: 0,0,0,1, PC, imm, S/B, 01; ALU ADD
  - 0x67 JALR: 1,0,0,0, rs1, imm, I, 11; ALU ADD
  - 0x6F JAL: 1,0,0,0, PC, imm, J, 10; ALU ADD
  - 0x17 AUIPC: 1,0,0,0, PC, imm, U, 00; ALU ADD
  - 0x37 LUI: 1,0,0,0, zero, imm, U, 00; ALU ADD
  - any other opcode: all outputs 0.
- ALU op for R-type, by func_3: 000 ADD (SUB if func_7_bit_6=1), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if func_7_bit_6=1), 110 OR, 111 AND.
- ALU op for I-ALU: same table, except 000 is always ADD; func_7_bit_6 matters only for 101.
- For load/store/branch/JAL/JALR/AUIPC/LUI, func_3 and func_7_bit_6 are ignored by every output except that the branch unit consumes func_3 directly.
- X/Z on inputs is not handled specially; defined inputs are required each cycle.

Test Plan:
- Reset: drive rst_n=0 mid-operation with opcode=0x33 held -> all outputs 0 immediately (no clock). Release -> next edge produces R-type decode.
- R-type sweep: opcode=0x33, func_7_bit_6=0, func_3=0..7 -> ALU ops 0,2,3,4,5,6,8,9, write=1, A=00, B=0, each one cycle after stimulus. Repeat with func_7_bit_6=1 -> func_3=000 gives 1 (SUB), 101 gives 7 (SRA), others unchanged.
- I-ALU: opcode=0x13, func_7_bit_6=1, func_3=000 -> ADD (0), B=1, imm=00. func_3=101 -> SRA (7).
- Memory: opcode=0x03 (all func_3) -> load=1, write=1, store=0, ALU 0, imm=00. opcode=0x23 -> store=1, write=0, imm=01.
- Control flow: 0x63 -> branch=1, A=01, nextpc=01, write=0. 0x6F -> nextpc=10, imm=11, write=1. 0x67 -> nextpc=11, A=00, imm=00.
- Upper immediates and illegal: 0x17 -> A=01, imm=10. 0x37 -> A=10, imm=10. opcode=0x00 or 0x7F with func_3=111 -> all outputs 0.

Source files
------------

// File: rtl/rv32i_control_unit_if.sv
// Decode-stage bundle: instruction fields in, registered datapath controls out.
interface rv32i_control_unit_if;
    logic [6:0] opcode;
    logic       func_7_bit_6;
    logic [2:0] func_3;
    logic       write;
    logic       store;
    logic       load;
    logic       branch;
    logic [1:0] alu_operand_a_selector;
    logic       alu_operand_b_selector;
    logic [1:0] immediate_selector;
    logic [1:0] next_pc_selector;
    logic [3:0] alu_operations_selector;

    modport master (
        output opcode, func_7_bit_6, func_3,
        input  write, store, load, branch,
        input  alu_operand_a_selector, alu_operand_b_selector,
        input  immediate_selector, next_pc_selector, alu_operations_selector
    );

    modport slave (
        input  opcode, func_7_bit_6, func_3,
        output write, store, load, branch,
        output alu_operand_a_selector, alu_operand_b_selector,
        output immediate_selector, next_pc_selector, alu_operations_selector
    );
endinterface

// File: rtl/rv32i_control_unit.sv
// RV32I main decoder; outputs form the control half of the decode/execute register.
module rv32i_control_unit (
    input  logic                   clk,
    input  logic                   rst_n,
    rv32i_control_unit_if.slave    bus
);
    localparam int unsigned OP_W  = 7;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned ALU_W = 4;

    localparam logic [OP_W-1:0] OP_R     = 7'h33;
    localparam logic [OP_W-1:0] OP_I     = 7'h13;
    localparam logic [OP_W-1:0] OP_LOAD  = 7'h03;
    localparam logic [OP_W-1:0] OP_STORE = 7'h23;
    localparam logic [OP_W-1:0] OP_BR    = 7'h63;
    localparam logic [OP_W-1:0] OP_JALR  = 7'h67;
    localparam logic [OP_W-1:0] OP_JAL   = 7'h6F;
    localparam logic [OP_W-1:0] OP_AUIPC = 7'h17;
    localparam logic [OP_W-1:0] OP_LUI   = 7'h37;

    localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALU_W-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'd8;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'd9;

    localparam logic [SEL_W-1:0] A_RS1  = 2'b00;
    localparam logic [SEL_W-1:0] A_PC   = 2'b01;
    localparam logic [SEL_W-1:0] A_ZERO = 2'b10;

    localparam logic [SEL_W-1:0] IMM_I  = 2'b00;
    localparam logic [SEL_W-1:0] IMM_SB = 2'b01;
    localparam logic [SEL_W-1:0] IMM_U  = 2'b10;
    localparam logic [SEL_W-1:0] IMM_J  = 2'b11;

    localparam logic [SEL_W-1:0] NPC_SEQ  = 2'b00;
    localparam logic [SEL_W-1:0] NPC_BR   = 2'b01;
    localparam logic [SEL_W-1:0] NPC_JAL  = 2'b10;
    localparam logic [SEL_W-1:0] NPC_JALR = 2'b11;

    logic             write_d, write_q;
    logic             store_d, store_q;
    logic             load_d, load_q;
    logic             branch_d, branch_q;
    logic [SEL_W-1:0] a_sel_d, a_sel_q;
    logic             b_sel_d, b_sel_q;
    logic [SEL_W-1:0] imm_sel_d, imm_sel_q;
    logic [SEL_W-1:0] npc_sel_d, npc_sel_q;
    logic [ALU_W-1:0] alu_op_d, alu_op_q;
    logic [ALU_W-1:0] arith_op_c;
    logic             sub_en_c;

    // Arithmetic op from funct3; SUB only exists in the register-register form.
    always_comb begin
        sub_en_c   = (bus.opcode == OP_R) && bus.func_7_bit_6;
        arith_op_c = ALU_ADD;
        unique case (bus.func_3)
            3'b000:  arith_op_c = sub_en_c ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op_c = ALU_SLL;
            3'b010:  arith_op_c = ALU_SLT;
            3'b011:  arith_op_c = ALU_SLTU;
            3'b100:  arith_op_c = ALU_XOR;
            3'b101:  arith_op_c = bus.func_7_bit_6 ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op_c = ALU_OR;
            default: arith_op_c = ALU_AND;
        endcase
    end

    // Main decode; unknown opcodes leave every control at zero (NOP).
    always_comb begin
        write_d   = 1'b0;
        store_d   = 1'b0;
        load_d    = 1'b0;
        branch_d  = 1'b0;
        a_sel_d   = A_RS1;
        b_sel_d   = 1'b0;
        imm_sel_d = IMM_I;
        npc_sel_d = NPC_SEQ;
        alu_op_d  = ALU_ADD;
        unique case (bus.opcode)
            OP_R: begin
                write_d  = 1'b1;
                alu_op_d = arith_op_c;
            end
            OP_I: begin
                write_d  = 1'b1;
                b_sel_d  = 1'b1;
                alu_op_d = arith_op_c;
            end
            OP_LOAD: begin
                write_d = 1'b1;
                load_d  = 1'b1;
                b_sel_d = 1'b1;
            end
            OP_STORE: begin
                store_d   = 1'b1;
                b_sel_d   = 1'b1;
                imm_sel_d = IMM_SB;
            end
            OP_BR: begin
                branch_d  = 1'b1;
                a_sel_d   = A_PC;
                b_sel_d   = 1'b1;
                imm_sel_d = IMM_SB;
                npc_sel_d = NPC_BR;
            end
            OP_JALR: begin
                write_d   = 1'b1;
                b_sel_d   = 1'b1;
                npc_sel_d = NPC_JALR;
            end
            OP_JAL: begin
                write_d   = 1'b1;
                a_sel_d   = A_PC;
                b_sel_d   = 1'b1;
                imm_sel_d = IMM_J;
                npc_sel_d = NPC_JAL;
            end
            OP_AUIPC: begin
                write_d   = 1'b1;
                a_sel_d   = A_PC;
                b_sel_d   = 1'b1;
                imm_sel_d = IMM_U;
            end
            OP_LUI: begin
                write_d   = 1'b1;
                a_sel_d   = A_ZERO;
                b_sel_d   = 1'b1;
                imm_sel_d = IMM_U;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q   <= 1'b0;
            store_q   <= 1'b0;
            load_q    <= 1'b0;
            branch_q  <= 1'b0;
            a_sel_q   <= A_RS1;
            b_sel_q   <= 1'b0;
            imm_sel_q <= IMM_I;
            npc_sel_q <= NPC_SEQ;
            alu_op_q  <= ALU_ADD;
        end else begin
            write_q   <= write_d;
            store_q   <= store_d;
            load_q    <= load_d;
            branch_q  <= branch_d;
            a_sel_q   <= a_sel_d;
            b_sel_q   <= b_sel_d;
            imm_sel_q <= imm_sel_d;
            npc_sel_q <= npc_sel_d;
            alu_op_q  <= alu_op_d;
        end
    end

    assign bus.write                   = write_q;
    assign bus.store                   = store_q;
    assign bus.load                    = load_q;
    assign bus.branch                  = branch_q;
    assign bus.alu_operand_a_selector  = a_sel_q;
    assign bus.alu_operand_b_selector  = b_sel_q;
    assign bus.immediate_selector      = imm_sel_q;
    assign bus.next_pc_selector        = npc_sel_q;
    assign bus.alu_operations_selector = alu_op_q;
endmodule

// File: tb/tb_rv32i_control_unit.sv
// Directed + table-driven bench for rv32i_control_unit with a per-cycle reference model.
module tb_rv32i_control_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    bit   cmp_en;

    rv32i_control_unit_if bus ();

    rv32i_control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {write,store,load,branch,A[1:0],B,imm[1:0],npc[1:0],alu[3:0]}
    function automatic logic [14:0] pk(int w, int s, int l, int b, int a, int bs,
                                       int imm, int npc, int alu);
        return {1'(w), 1'(s), 1'(l), 1'(b), 2'(a), 1'(bs), 2'(imm), 2'(npc), 4'(alu)};
    endfunction

    // Reference: decode table rows plus the funct3 ALU table.
    function automatic logic [14:0] model(logic [6:0] op, logic f7, logic [2:0] f3);
        int alu_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int alu;
        alu = alu_tab[f3];
        if (f7 && f3 == 3'd5) alu = 7;
        case (op)
            7'h33: begin
                if (f7 && f3 == 3'd0) alu = 1;
                return pk(1, 0, 0, 0, 0, 0, 0, 0, alu);
            end
            7'h13:   return pk(1, 0, 0, 0, 0, 1, 0, 0, alu);
            7'h03:   return pk(1, 0, 1, 0, 0, 1, 0, 0, 0);
            7'h23:   return pk(0, 1, 0, 0, 0, 1, 1, 0, 0);
            7'h63:   return pk(0, 0, 0, 1, 1, 1, 1, 1, 0);
            7'h67:   return pk(1, 0, 0, 0, 0, 1, 0, 3, 0);
            7'h6F:   return pk(1, 0, 0, 0, 1, 1, 3, 2, 0);
            7'h17:   return pk(1, 0, 0, 0, 1, 1, 2, 0, 0);
            7'h37:   return pk(1, 0, 0, 0, 2, 1, 2, 0, 0);
            default: return 15'd0;
        endcase
    endfunction

    logic [14:0] act;
    logic [14:0] exp_q;
    assign act = {bus.write, bus.store, bus.load, bus.branch, bus.alu_operand_a_selector,
                  bus.alu_operand_b_selector, bus.immediate_selector, bus.next_pc_selector,
                  bus.alu_operations_selector};

    // Model state tracks the one-cycle capture and the asynchronous clear.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q = 15'd0;
        else        exp_q = model(bus.opcode, bus.func_7_bit_6, bus.func_3);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (act !== exp_q) begin
                errors++;
                $display("FAIL model op=%h f7=%b f3=%0d got=%h want=%h t=%0t",
                         bus.opcode, bus.func_7_bit_6, bus.func_3, act, exp_q, $time);
            end
        end
    end

    task automatic check_lit(string name, logic [14:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, want, $time);
        end
    endtask

    task automatic apply(logic [6:0] op, logic f7, logic [2:0] f3);
        @(negedge clk);
        bus.opcode       = op;
        bus.func_7_bit_6 = f7;
        bus.func_3       = f3;
    endtask

    task automatic step_check(string name, logic [6:0] op, logic f7, logic [2:0] f3,
                              logic [14:0] want);
        apply(op, f7, f3);
        @(posedge clk);
        #1;
        check_lit(name, want);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int alu_f0 [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int alu_f1 [8] = '{1, 2, 3, 4, 5, 7, 8, 9};
        logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                 7'h67, 7'h6F, 7'h17, 7'h37, 7'h00};
        checks = 0;
        errors = 0;
        cmp_en = 1'b0;
        rst_n  = 1'b0;
        bus.opcode       = 7'h33;
        bus.func_7_bit_6 = 1'b0;
        bus.func_3       = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check_lit("reset_state", 15'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        cmp_en = 1'b1;

        for (int i = 0; i < 8; i++)
            step_check("r_sweep_f7_0", 7'h33, 1'b0, 3'(i), pk(1, 0, 0, 0, 0, 0, 0, 0, alu_f0[i]));
        for (int i = 0; i < 8; i++)
            step_check("r_sweep_f7_1", 7'h33, 1'b1, 3'(i), pk(1, 0, 0, 0, 0, 0, 0, 0, alu_f1[i]));

        step_check("i_add_f7", 7'h13, 1'b1, 3'd0, pk(1, 0, 0, 0, 0, 1, 0, 0, 0));
        step_check("i_sra",    7'h13, 1'b1, 3'd5, pk(1, 0, 0, 0, 0, 1, 0, 0, 7));
        step_check("i_srl",    7'h13, 1'b0, 3'd5, pk(1, 0, 0, 0, 0, 1, 0, 0, 6));
        for (int i = 0; i < 8; i++)
            step_check("load", 7'h03, 1'(i & 1), 3'(i), pk(1, 0, 1, 0, 0, 1, 0, 0, 0));
        step_check("store",  7'h23, 1'b1, 3'd3, pk(0, 1, 0, 0, 0, 1, 1, 0, 0));
        step_check("branch", 7'h63, 1'b1, 3'd1, pk(0, 0, 0, 1, 1, 1, 1, 1, 0));
        step_check("jal",    7'h6F, 1'b0, 3'd7, pk(1, 0, 0, 0, 1, 1, 3, 2, 0));
        step_check("jalr",   7'h67, 1'b1, 3'd5, pk(1, 0, 0, 0, 0, 1, 0, 3, 0));
        step_check("auipc",  7'h17, 1'b1, 3'd0, pk(1, 0, 0, 0, 1, 1, 2, 0, 0));
        step_check("lui",    7'h37, 1'b0, 3'd5, pk(1, 0, 0, 0, 2, 1, 2, 0, 0));

        // Outputs must hold the previous decode until the next rising edge.
        apply(7'h00, 1'b0, 3'd7);
        #1;
        check_lit("hold_until_edge", pk(1, 0, 0, 0, 2, 1, 2, 0, 0));
        @(posedge clk);
        #1;
        check_lit("illegal_00", 15'd0);
        step_check("illegal_7f", 7'h7F, 1'b1, 3'd7, 15'd0);

        // Asynchronous reset with R-type held, then recovery on the next edge.
        step_check("pre_reset_sub", 7'h33, 1'b1, 3'd0, pk(1, 0, 0, 0, 0, 0, 0, 0, 1));
        #1 rst_n = 1'b0;
        #1;
        check_lit("async_reset", 15'd0);
        @(posedge clk);
        #1;
        check_lit("reset_held", 15'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_lit("post_reset_sub", pk(1, 0, 0, 0, 0, 0, 0, 0, 1));

        for (int i = 0; i < 60; i++)
            apply(ops[$urandom_range(0, 9)], 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
